// File: rtl/telemetry_velocity.sv
// telemetry_velocity
//    Samples an unsigned 3-axis position once every PERIOD enabled clocks. It
//    reports the per-axis difference from the previous sample as a saturated
//    8-bit two's-complement velocity.
//
// Ports
//    clk                      single clock, rising edge
//    rst_n                    synchronous active-low reset (priority over clr/en)
//    en                       sampling enable; low freezes the interval counter
//    clr                      synchronous flush back to EMPTY
//    coord_x/y/z   [7:0]      registered unsigned position
//    vel_x/y/z     [7:0]      signed velocity, position units per interval
//    vel_valid                one-cycle strobe for new vel_*/sat
//    sat           [2:0]      per-axis clamp flags {z, y, x}
//    primed                   high while a previous sample is held (RUN)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_EMPTY | no previous sample; the next sample event only captures coords
// ST_RUN   | previous sample held; each sample event emits a velocity
module telemetry_velocity #(
   parameter int unsigned PERIOD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       clr,
   input  logic [7:0] coord_x,
   input  logic [7:0] coord_y,
   input  logic [7:0] coord_z,
   output logic [7:0] vel_x,
   output logic [7:0] vel_y,
   output logic [7:0] vel_z,
   output logic       vel_valid,
   output logic [2:0] sat,
   output logic       primed
);

   localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  prev_x_q, prev_x_d;
   logic [7:0]  prev_y_q, prev_y_d;
   logic [7:0]  prev_z_q, prev_z_d;
   logic [7:0]  vel_x_q, vel_x_d;
   logic [7:0]  vel_y_q, vel_y_d;
   logic [7:0]  vel_z_q, vel_z_d;
   logic [2:0]  sat_q, sat_d;
   logic        vel_valid_q, vel_valid_d;

   logic        sample;
   logic [8:0]  diff_x, diff_y, diff_z;

   // Returns {clamped, velocity}. A 9-bit result fits in 8 signed bits only
   // when its top two bits agree; otherwise the sign bit picks the rail.
   function automatic logic [8:0] clamp_diff(input logic [7:0] cur,
                                             input logic [7:0] prv);
      logic [8:0] d;
      d = {1'b0, cur} - {1'b0, prv};
      if (d[8] == d[7]) begin
         clamp_diff = {1'b0, d[7:0]};
      end else if (!d[8]) begin
         clamp_diff = {1'b1, 8'h7F};
      end else begin
         clamp_diff = {1'b1, 8'h80};
      end
   endfunction

   assign sample = en && (cnt_q == CNT_LAST);
   assign diff_x = clamp_diff(coord_x, prev_x_q);
   assign diff_y = clamp_diff(coord_y, prev_y_q);
   assign diff_z = clamp_diff(coord_z, prev_z_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      prev_x_d    = prev_x_q;
      prev_y_d    = prev_y_q;
      prev_z_d    = prev_z_q;
      vel_x_d     = vel_x_q;
      vel_y_d     = vel_y_q;
      vel_z_d     = vel_z_q;
      sat_d       = sat_q;
      vel_valid_d = 1'b0;

      if (clr) begin
         // Flush wins over a coincident sample: no capture, no strobe.
         state_d = ST_EMPTY;
         cnt_d   = '0;
      end else if (en) begin
         if (sample) begin
            cnt_d    = '0;
            prev_x_d = coord_x;
            prev_y_d = coord_y;
            prev_z_d = coord_z;
            state_d  = ST_RUN;
            if (state_q == ST_RUN) begin
               vel_x_d     = diff_x[7:0];
               vel_y_d     = diff_y[7:0];
               vel_z_d     = diff_z[7:0];
               sat_d       = {diff_z[8], diff_y[8], diff_x[8]};
               vel_valid_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         cnt_q       <= '0;
         prev_x_q    <= '0;
         prev_y_q    <= '0;
         prev_z_q    <= '0;
         vel_x_q     <= '0;
         vel_y_q     <= '0;
         vel_z_q     <= '0;
         sat_q       <= '0;
         vel_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         prev_x_q    <= prev_x_d;
         prev_y_q    <= prev_y_d;
         prev_z_q    <= prev_z_d;
         vel_x_q     <= vel_x_d;
         vel_y_q     <= vel_y_d;
         vel_z_q     <= vel_z_d;
         sat_q       <= sat_d;
         vel_valid_q <= vel_valid_d;
      end
   end

   assign vel_x     = vel_x_q;
   assign vel_y     = vel_y_q;
   assign vel_z     = vel_z_q;
   assign sat       = sat_q;
   assign vel_valid = vel_valid_q;
   assign primed    = (state_q == ST_RUN);

endmodule

// File: tb/tb_telemetry_velocity.sv
module tb_telemetry_velocity;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic [7:0] coord_x, coord_y, coord_z;
   logic [7:0] vel_x, vel_y, vel_z;
   logic       vel_valid;
   logic [2:0] sat;
   logic       primed;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int         cyc;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] z;
      logic [2:0] s;
   } exp_t;

   exp_t exp_q[$];

   telemetry_velocity #(.PERIOD(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .clr       (clr),
      .coord_x   (coord_x),
      .coord_y   (coord_y),
      .coord_z   (coord_z),
      .vel_x     (vel_x),
      .vel_y     (vel_y),
      .vel_z     (vel_z),
      .vel_valid (vel_valid),
      .sat       (sat),
      .primed    (primed)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; a strobe launched by edge N is seen
   // by the monitor with cyc == N.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // Scoreboard monitor: every strobe must match the head of the queue in
   // both arrival cycle and payload.
   always @(negedge clk) begin
      if (vel_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe: strobe at cycle %0d, none expected", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cyc != e.cyc || vel_x !== e.x || vel_y !== e.y || vel_z !== e.z || sat !== e.s) begin
               failures++;
               $display("FAIL strobe: got cyc=%0d vel=(%0h,%0h,%0h) sat=%b expected cyc=%0d vel=(%0h,%0h,%0h) sat=%b",
                        cyc, vel_x, vel_y, vel_z, sat, e.cyc, e.x, e.y, e.z, e.s);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full enabled interval starting with cnt=0.
   task automatic sample_interval(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                                  input bit strobe, input logic [7:0] ex, input logic [7:0] ey,
                                  input logic [7:0] ez, input logic [2:0] es);
      coord_x = x; coord_y = y; coord_z = z;
      en = 1'b1;
      if (strobe) exp_q.push_back('{cyc + 4, ex, ey, ez, es});
      step(4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; clr = 1'b0;
      coord_x = 8'd0; coord_y = 8'd0; coord_z = 8'd0;
      step(2);
      rst_n = 1'b1;
      chk("rst_vel_x", 32'(vel_x), 32'h0);
      chk("rst_vel_y", 32'(vel_y), 32'h0);
      chk("rst_vel_z", 32'(vel_z), 32'h0);
      chk("rst_sat", 32'(sat), 32'h0);
      chk("rst_valid", 32'(vel_valid), 32'h0);
      chk("rst_primed", 32'(primed), 32'h0);

      // First interval captures only, second emits zero velocity.
      sample_interval(8'd10, 8'd20, 8'd30, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
      chk("first_capture_primed", 32'(primed), 32'h1);
      sample_interval(8'd10, 8'd20, 8'd30, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
      chk("run_primed", 32'(primed), 32'h1);

      sample_interval(8'd15, 8'd18, 8'd30, 1'b1, 8'h05, 8'hFE, 8'h00, 3'b000);
      // (15,18,30)->(0,255,100): -15, +237 clamps to 127, +70
      sample_interval(8'd0, 8'd255, 8'd100, 1'b1, 8'hF1, 8'h7F, 8'h46, 3'b010);
      sample_interval(8'd200, 8'd0, 8'd100, 1'b1, 8'h7F, 8'h80, 8'h00, 3'b011);
      chk("sat_hold", 32'(sat), 32'h3);

      // Ten-cycle pause after two enabled cycles delays the strobe by ten.
      coord_x = 8'd201; coord_y = 8'd2; coord_z = 8'd90;
      en = 1'b1;
      exp_q.push_back('{cyc + 14, 8'h01, 8'h02, 8'hF6, 3'b000});
      step(2);
      en = 1'b0;
      step(10);
      chk("pause_vel_hold", 32'(vel_x), 32'h7F);
      chk("pause_primed", 32'(primed), 32'h1);
      en = 1'b1;
      step(2);

      // clr on the sample edge: no strobe, back to EMPTY, velocity kept.
      coord_x = 8'd60; coord_y = 8'd60; coord_z = 8'd60;
      step(3);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("clr_primed", 32'(primed), 32'h0);
      chk("clr_valid", 32'(vel_valid), 32'h0);
      chk("clr_vel", {8'h0, vel_x, vel_y, vel_z}, 32'h000102F6);
      chk("clr_sat", 32'(sat), 32'h0);
      sample_interval(8'd50, 8'd50, 8'd50, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
      chk("clr_recapture_primed", 32'(primed), 32'h1);
      sample_interval(8'd50, 8'd50, 8'd50, 1'b1, 8'h00, 8'h00, 8'h00, 3'b000);
      sample_interval(8'd60, 8'd45, 8'd50, 1'b1, 8'h0A, 8'hFB, 8'h00, 3'b000);

      // Reset mid-interval (cnt=2) in RUN.
      coord_x = 8'd70; coord_y = 8'd80; coord_z = 8'd90;
      en = 1'b1;
      step(2);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      chk("midrst_vel", {8'h0, vel_x, vel_y, vel_z}, 32'h0);
      chk("midrst_sat", 32'(sat), 32'h0);
      chk("midrst_valid", 32'(vel_valid), 32'h0);
      chk("midrst_primed", 32'(primed), 32'h0);
      sample_interval(8'd70, 8'd80, 8'd90, 1'b0, 8'h00, 8'h00, 8'h00, 3'b000);
      chk("midrst_capture_primed", 32'(primed), 32'h1);
      sample_interval(8'd72, 8'd80, 8'd89, 1'b1, 8'h02, 8'h00, 8'hFF, 3'b000);

      en = 1'b0;
      step(3);
      chk("pending_strobes", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
